instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer side of the instruction memory: accepts a byte stream (UART receiver or board switches) and writes little-endian 32-bit instruction words into the writable instruction RAM at word-aligned byte addresses 0x00, 0x04, 0x08, …
- Holds the CPU in reset (cpu_hold) while a load is in progress, then releases it so fetch restarts from address 0x00.
- Sits between the byte source and the instruction RAM write port; the CPU read port (8-bit byte address, 32-bit read data) is unaffected.

Parameters:
- AW, 8, byte address width of the instruction memory.
- DEPTH, 64, max words loadable (2^AW / 4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse, begins a load.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  one-cycle RAM write strobe.
- wr_addr  out  AW  byte address of write, always word-aligned (low 2 bits 0).
- wr_data  out  32  instruction word.
- cpu_hold  out  1  CPU held in reset.
- busy  out  1  load in progress.
- done  out  1  last load completed OK; sticky until next start.
- err  out  1  last load failed; sticky until next start.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; word/byte counters, word register and checksum cleared.
- Transfer: a byte transfers on a rising edge where byte_valid && byte_ready. byte_ready = 1 only in HDR, DATA and CHK.
- States and transitions:
  - IDLE: start → HDR.
  - HDR: accepted byte is N (word count).
    - N == 0 or N > DEPTH → ERR.
    - Otherwise latch N → DATA.
  - DATA: bytes assemble little-endian (first byte → bits 7:0, fourth → 31:24).
    - On the edge accepting a word's 4th byte, register wr_data, wr_addr = 4 × word_idx and wr_en = 1. These are visible in the next cycle for exactly one cycle. Then word_idx increments.
    - No stall: byte_ready stays 1 during the wr_en cycle, so back-to-back bytes are accepted.
    - After word N−1 is written → DONE, or → CHK when the optional feature is compiled in.
  - DONE: done = 1. start → HDR.
  - ERR: err = 1. start → HDR.
- start handling: ignored in HDR/DATA/CHK. In IDLE/DONE/ERR, start clears done/err on the same edge it enters HDR.
- Output decode:
  - busy = 1 in HDR, DATA, CHK.
  - cpu_hold = 1 in HDR, DATA, CHK, ERR; 0 in IDLE, DONE.
- Address wrap: impossible by construction (N ≤ DEPTH). word_idx width is log2(DEPTH)+1.
- Partial word: if the stream stops mid-word, the loader waits indefinitely; there is no timeout. Recovery is by rst only.
- Reset mid-load: immediate return to IDLE; a wr_en in flight is dropped. Already-written RAM words are not restored.
- wr_data / wr_addr hold their last values when wr_en = 0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte the FSM enters CHK and accepts one byte.
  - Pass if it equals the XOR of the header byte and all data bytes → DONE; else → ERR.
  - Words are already written regardless of the checksum result.
- Undefined: no CHK state; DATA → DONE directly. Any byte after the last data byte is not accepted (byte_ready = 0).

Decomposition:
- Package loader_pkg: state enum (IDLE, HDR, DATA, CHK, DONE, ERR), DEPTH_DEFAULT = 64, WORD_BYTES = 4.
- Sub-module byte_assembler: 2-bit byte counter plus 32-bit little-endian shift/assemble register.
  - Inputs: byte, strobe, clear.
  - Outputs: word and a word_done pulse.
  - The FSM, address counter and checksum stay in the top.

Test Plan:
- Load 2 words: start, then bytes 02, 13 02 70 00, 93 00 20 00 → wr_en pulses with (00, 0x00700213) and (04, 0x00200093); done = 1, cpu_hold = 0, err = 0.
- Header 00, and separately header 0x41 (65) → ERR, err = 1, cpu_hold = 1, no wr_en; a following start plus a valid 1-word load clears err and sets done.
- Continuous byte_valid for a 64-word load → 64 wr_en pulses, last at wr_addr 0xFC, no byte dropped, byte_ready never low in DATA.
- Assert rst after 6 data bytes of a 3-word load → all outputs 0 immediately; 1 write seen (addr 00), none after.
- Start pulse during DATA → ignored; load completes with the original N.
- With LOADER_CHECKSUM_EN, load 01, 13 02 70 00, then checksum 0x60 → DONE; the same load with checksum 0x61 → ERR, and the word was still written at 00.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    localparam int DEPTH_DEFAULT = 64;
    localparam int WORD_BYTES    = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// Collects four stream bytes into one little-endian 32-bit word.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_byte,
    input  logic        strobe,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  cnt;
    logic [23:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sr  <= '0;
        end else if (clear) begin
            cnt <= '0;
            sr  <= '0;
        end else if (strobe) begin
            cnt <= cnt + 2'd1;
            sr  <= {data_byte, sr[23:8]};
        end
    end

    // The fourth byte is combined directly so the word is ready on the accepting edge.
    always_comb begin
        word      = {data_byte, sr};
        word_done = strobe && (cnt == 2'(WORD_BYTES - 1));
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction RAM; holds the CPU in reset while loading.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int IW = $clog2(DEPTH) + 1;

    state_t        state, nxt;
    logic [IW-1:0] word_idx;
    logic [IW-1:0] n_words;
    logic          accept;
    logic          start_ok;
    logic          hdr_bad;
    logic          last_word;
    logic          asm_strobe;
    logic          asm_done;
    logic [31:0]   asm_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .data_byte (byte_in),
        .strobe    (asm_strobe),
        .clear     (start_ok),
        .word      (asm_word),
        .word_done (asm_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt        = state;
        byte_ready = (state == HDR) || (state == DATA) || (state == CHK);
        busy       = byte_ready;
        cpu_hold   = byte_ready || (state == ERR);
        done       = (state == DONE);
        err        = (state == ERR);
        accept     = byte_valid && byte_ready;
        start_ok   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
        hdr_bad    = (byte_in == 8'd0) || ({24'd0, byte_in} > 32'(DEPTH));
        last_word  = (word_idx == (n_words - IW'(1)));
        asm_strobe = accept && (state == DATA);

        case (state)
            IDLE, DONE, ERR: if (start) nxt = HDR;
            HDR:             if (accept) nxt = hdr_bad ? ERR : DATA;
            DATA: begin
                if (asm_done && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    nxt = CHK;
`else
                    nxt = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK:             if (accept) nxt = (byte_in == csum) ? DONE : ERR;
`endif
            default:         nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx <= '0;
            n_words  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (start_ok) word_idx <= '0;
            if ((state == HDR) && accept) n_words <= IW'(byte_in);
            if (asm_done) begin
                wr_en    <= 1'b1;
                wr_data  <= asm_word;
                wr_addr  <= AW'({word_idx, 2'b00});
                word_idx <= word_idx + IW'(1);
            end
`ifdef LOADER_CHECKSUM_EN
            if ((state == HDR) && accept) csum <= byte_in;
            if (asm_strobe)               csum <= csum ^ byte_in;
`endif
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a stream-level model.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    instr_mem_loader #(.AW(8), .DEPTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int stalls      = 0;

    logic [7:0]  got_addr[$];
    logic [31:0] got_data[$];
    logic [7:0]  data_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        tries      = 0;
        while (byte_ready !== 1'b1 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (byte_ready !== 1'b1) begin
            check("ready_timeout", {31'd0, byte_ready}, 32'd1);
            byte_valid = 1'b0;
            return;
        end
        if (tries > 0) stalls++;
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},    {31'd0, wr_en},      32'd0);
        check({tag, "_wr_addr"},  {24'd0, wr_addr},    32'd0);
        check({tag, "_wr_data"},  wr_data,             32'd0);
        check({tag, "_ready"},    {31'd0, byte_ready}, 32'd0);
        check({tag, "_hold"},     {31'd0, cpu_hold},   32'd0);
        check({tag, "_busy"},     {31'd0, busy},       32'd0);
        check({tag, "_done"},     {31'd0, done},       32'd0);
        check({tag, "_err"},      {31'd0, err},        32'd0);
    endtask

    // Model: a good header N yields N writes of little-endian words at 4*i;
    // the outcome is done unless the header is out of range (or the checksum mismatches).
    task automatic run_load(input logic [7:0] hdr, input int gapmax, input int mid, input logic [7:0] chk);
        logic       bad;
        logic       ok;
        logic [7:0] x;
        int         nw;
        bad = (hdr == 8'd0) || (hdr > 8'd64);
        ok  = !bad;
        nw  = bad ? 0 : int'(hdr);
        x   = hdr;
        got_addr.delete();
        got_data.delete();
        send_byte(hdr, int'($urandom_range(gapmax, 0)));
        if (!bad) begin
            for (int i = 0; i < 4 * nw; i++) begin
                if (i == mid) pulse_start();
                send_byte(data_q[i], int'($urandom_range(gapmax, 0)));
                x ^= data_q[i];
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(chk, int'($urandom_range(gapmax, 0)));
            ok = (chk == x);
`else
            if (chk == x) ok = 1'b1;
`endif
        end
        repeat (2) @(negedge clk);
        check("nwrites", got_addr.size(), nw);
        for (int i = 0; i < nw && i < got_addr.size(); i++) begin
            check("addr", {24'd0, got_addr[i]}, 4 * i);
            check("data", got_data[i],
                  {data_q[4*i+3], data_q[4*i+2], data_q[4*i+1], data_q[4*i]});
        end
        check("done",     {31'd0, done},       {31'd0, ok});
        check("err",      {31'd0, err},        {31'd0, !ok});
        check("cpu_hold", {31'd0, cpu_hold},   {31'd0, !ok});
        check("busy",     {31'd0, busy},       32'd0);
        check("ready",    {31'd0, byte_ready}, 32'd0);
    endtask

    function automatic logic [7:0] xor_of(input logic [7:0] hdr);
        logic [7:0] x;
        x = hdr;
        for (int i = 0; i < 4 * int'(hdr) && i < data_q.size(); i++) x ^= data_q[i];
        return x;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] h;
        int         mid;
        int         r;
        rst        = 1'b1;
        start      = 1'b0;
        byte_in    = '0;
        byte_valid = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Two-word load from the example stream
        data_q = '{8'h13, 8'h02, 8'h70, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
        pulse_start();
        run_load(8'h02, 0, -1, xor_of(8'h02));
        if (got_data.size() == 2) begin
            check("ex_word0", got_data[0], 32'h0070_0213);
            check("ex_word1", got_data[1], 32'h0020_0093);
        end

        // Header out of range, then recovery
        pulse_start();
        run_load(8'h00, 1, -1, 8'h00);
        pulse_start();
        run_load(8'h41, 1, -1, 8'h00);
        data_q = '{8'h13, 8'h02, 8'h70, 8'h00};
        pulse_start();
        run_load(8'h01, 1, -1, xor_of(8'h01));

        // Full-depth load with continuous valid
        data_q.delete();
        for (int i = 0; i < 256; i++) data_q.push_back(8'($urandom_range(255, 0)));
        stalls = 0;
        pulse_start();
        run_load(8'd64, 0, -1, xor_of(8'd64));
        check("stalls64", stalls, 0);
        if (got_addr.size() == 64) check("last_addr", {24'd0, got_addr[63]}, 32'h0000_00FC);

        // Reset in the middle of a three-word load
        got_addr.delete();
        got_data.delete();
        pulse_start();
        send_byte(8'd3, 0);
        for (int i = 0; i < 6; i++) send_byte(data_q[i], 0);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_nwrites", got_addr.size(), 1);
        if (got_addr.size() >= 1) check("midrst_addr", {24'd0, got_addr[0]}, 32'd0);

        // Start pulse during DATA is ignored
        pulse_start();
        run_load(8'd2, 1, 3, xor_of(8'd2));

`ifdef LOADER_CHECKSUM_EN
        data_q = '{8'h13, 8'h02, 8'h70, 8'h00};
        pulse_start();
        run_load(8'h01, 0, -1, 8'h60);
        check("chk_pass_done", {31'd0, done}, 32'd1);
        pulse_start();
        run_load(8'h01, 0, -1, 8'h61);
        check("chk_fail_err", {31'd0, err}, 32'd1);
`endif

        // Randomized loads
        for (int t = 0; t < 24; t++) begin
            data_q.delete();
            for (int i = 0; i < 32; i++) data_q.push_back(8'($urandom_range(255, 0)));
            r = int'($urandom_range(7, 0));
            if (r == 0) h = ($urandom_range(1, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 65));
            else        h = 8'($urandom_range(8, 1));
            mid = -1;
            if (h >= 8'd1 && h <= 8'd8 && $urandom_range(3, 0) == 0)
                mid = int'($urandom_range(4 * int'(h) - 1, 1));
            pulse_start();
            if ($urandom_range(1, 0) == 0) run_load(h, 3, mid, xor_of(h));
            else                           run_load(h, 3, mid, xor_of(h) ^ 8'($urandom_range(255, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
